// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM between a processor (M0) and a loader/debug port (M1).
// One transaction in flight; req/ack handshake per requester and fixed-latency reads.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int RD_LATENCY = 1
) (
   input  logic                clk,
   input  logic                resetn,

   input  logic                m0_req,
   input  logic                m0_we,
   input  logic [ADDR_W-1:0]   m0_addr,
   input  logic [DATA_W-1:0]   m0_wdata,
   input  logic [DATA_W/8-1:0] m0_wmask,
   output logic                m0_ack,
   output logic [DATA_W-1:0]   m0_rdata,

   input  logic                m1_req,
   input  logic                m1_we,
   input  logic [ADDR_W-1:0]   m1_addr,
   input  logic [DATA_W-1:0]   m1_wdata,
   input  logic [DATA_W/8-1:0] m1_wmask,
   output logic                m1_ack,
   output logic [DATA_W-1:0]   m1_rdata,

   output logic [ADDR_W-1:0]   mem_addr,
   output logic                mem_rstrb,
   output logic [DATA_W/8-1:0] mem_wmask,
   output logic [DATA_W-1:0]   mem_wdata,
   input  logic [DATA_W-1:0]   mem_rdata,

   output logic [1:0]          grant
);

   localparam logic [3:0] CNT_INIT = 4'(RD_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t     state;
   logic       last_grant;
   logic [3:0] cnt;
   logic       pick_m1;

   // A lone request wins; on a tie the requester that was not served last wins.
   always_comb begin
      pick_m1 = m1_req && (!m0_req || !last_grant);
   end

   // The RAM-facing outputs double as the latched request, so they are loaded at the grant edge.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         cnt        <= '0;
         grant      <= '0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_rstrb  <= 1'b0;
         mem_wmask  <= '0;
         m0_ack     <= 1'b0;
         m1_ack     <= 1'b0;
         m0_rdata   <= '0;
         m1_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (m0_req || m1_req) begin
                  state      <= ISSUE;
                  last_grant <= pick_m1;
                  grant      <= pick_m1 ? 2'b10 : 2'b01;
                  mem_addr   <= pick_m1 ? m1_addr  : m0_addr;
                  mem_wdata  <= pick_m1 ? m1_wdata : m0_wdata;
                  if (pick_m1 ? m1_we : m0_we) begin
                     mem_rstrb <= 1'b0;
                     mem_wmask <= pick_m1 ? m1_wmask : m0_wmask;
                  end else begin
                     mem_rstrb <= 1'b1;
                     mem_wmask <= '0;
                  end
               end
            end

            // mem_rstrb still tells us whether this transaction is a read.
            ISSUE: begin
               mem_rstrb <= 1'b0;
               mem_wmask <= '0;
               if (mem_rstrb) begin
                  state <= WAIT;
                  cnt   <= CNT_INIT;
               end else begin
                  state  <= RESP;
                  m0_ack <= grant[0];
                  m1_ack <= grant[1];
               end
            end

            WAIT: begin
               if (cnt == 4'd0) begin
                  state <= RESP;
                  if (grant[1]) begin
                     m1_rdata <= mem_rdata;
                     m1_ack   <= 1'b1;
                  end else begin
                     m0_rdata <= mem_rdata;
                     m0_ack   <= 1'b1;
                  end
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            RESP: begin
               state  <= IDLE;
               grant  <= '0;
               m0_ack <= 1'b0;
               m1_ack <= 1'b0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
